// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default widths for the GCD execution unit.
package gcd_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} gcd_state_t;
    localparam int GCD_WIDTH = 8;
    localparam int GCD_CNT_W = 16;
endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational subtraction step of Euclid's algorithm.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        done   = (a == '0) || (b == '0) || (a == b);
        result = (a == '0) ? b : a;
        // the larger operand is always the minuend, so no underflow
        a_nxt  = (!done && a > b) ? a - b : a;
        b_nxt  = (!done && b > a) ? b - a : b;
    end
endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: multicycle subtraction-based GCD with valid/ready in and out,
// one step per cycle and a saturating iteration count.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = GCD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_out,
    output logic             busy
);
    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, iter_q, iter_d;
    logic [WIDTH-1:0] a_nxt, b_nxt, result;
    logic             done;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_q),
        .b      (b_q),
        .a_nxt  (a_nxt),
        .b_nxt  (b_nxt),
        .done   (done),
        .result (result)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a_in;
                b_d     = b_in;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: if (done) begin
                gcd_d   = result;
                iter_d  = cnt_q;
                state_d = DONE;
            end else begin
                a_d   = a_nxt;
                b_d   = b_nxt;
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign gcd_out   = gcd_q;
    assign iter_out  = iter_q;
endmodule
